// File: rtl/truth_table_capture_if.sv
// Bundle between the truth-table sweeper (slave) and whoever starts sweeps
// and hosts the combinational lab DUT (master).
interface truth_table_capture_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      stim;
  logic                 dut_out;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   captured;
  logic [N_IN:0]        mismatch_cnt;
  logic                 fail_valid;
  logic [N_IN-1:0]      first_fail;
  logic                 pass;

  modport slave (
    input  start, dut_out,
    output stim, busy, done, captured, mismatch_cnt, fail_valid, first_fail, pass
  );

  modport master (
    output start, dut_out,
    input  stim, busy, done, captured, mismatch_cnt, fail_valid, first_fail, pass
  );
endinterface

// File: rtl/truth_table_capture.sv
// Sweeps every input vector of a combinational lab DUT, holds each for SETTLE
// cycles, captures the output truth table and grades it against EXP_TT.
module truth_table_capture #(
  parameter int                 N_IN   = 3,
  parameter int                 SETTLE = 4,
  parameter logic [2**N_IN-1:0] EXP_TT = 8'b1110_1000
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_capture_if.slave bus
);

  localparam int HCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HCW-1:0]  HC_LAST   = HCW'(SETTLE - 1);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [HCW-1:0] hc;

  // stim doubles as the vector index, so the applied vector and the
  // captured bit position can never drift apart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      hc               <= '0;
      bus.stim         <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.captured     <= '0;
      bus.mismatch_cnt <= '0;
      bus.fail_valid   <= 1'b0;
      bus.first_fail   <= '0;
      bus.pass         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state            <= RUN;
            hc               <= '0;
            bus.stim         <= '0;
            bus.busy         <= 1'b1;
            bus.captured     <= '0;
            bus.mismatch_cnt <= '0;
            bus.fail_valid   <= 1'b0;
            bus.first_fail   <= '0;
            bus.pass         <= 1'b0;
          end
        end

        RUN: begin
          if (hc == HC_LAST) begin
            hc                     <= '0;
            bus.captured[bus.stim] <= bus.dut_out;
            if (bus.dut_out != EXP_TT[bus.stim]) begin
              bus.mismatch_cnt <= bus.mismatch_cnt + (N_IN+1)'(1);
              if (!bus.fail_valid) begin
                bus.first_fail <= bus.stim;
                bus.fail_valid <= 1'b1;
              end
            end
            if (bus.stim == STIM_LAST) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              bus.stim <= bus.stim + N_IN'(1);
            end
          end else begin
            hc <= hc + HCW'(1);
          end
        end

        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.stim <= '0;
          bus.pass <= (bus.mismatch_cnt == '0);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: expected sweep results are queued
// when a sweep starts and compared when the sweep reports done.
module tb_truth_table_capture;

  localparam int          N_IN   = 3;
  localparam int          SETTLE = 4;
  localparam int          DEPTH  = 8;
  localparam logic [7:0]  EXP_TT = 8'hE8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;
  int total = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] cap;
    logic [3:0] cnt;
    logic       fv;
    logic [2:0] ff;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  // 0: majority, 1: stuck-at-0, other: 3-input XOR
  function automatic logic dut_fn(input int m, input logic [2:0] v);
    case (m)
      0:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      1:       return 1'b0;
      default: return ^v;
    endcase
  endfunction

  function automatic exp_t model(input int m);
    exp_t e;
    logic [2:0] v;
    logic b;
    e.cap = '0; e.cnt = '0; e.fv = 1'b0; e.ff = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v = 3'(i);
      b = dut_fn(m, v);
      e.cap[i] = b;
      if (b != EXP_TT[i]) begin
        e.cnt = e.cnt + 4'd1;
        if (!e.fv) begin
          e.fv = 1'b1;
          e.ff = v;
        end
      end
    end
    e.pass = (e.cnt == 0);
    return e;
  endfunction

  truth_table_capture_if #(.N_IN(N_IN)) bus ();
  truth_table_capture_if #(.N_IN(N_IN)) bus1 ();

  assign bus.dut_out  = dut_fn(mode, bus.stim);
  assign bus1.dut_out = dut_fn(0, bus1.stim);

  truth_table_capture #(.N_IN(N_IN), .SETTLE(SETTLE), .EXP_TT(EXP_TT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  truth_table_capture #(.N_IN(N_IN), .SETTLE(1), .EXP_TT(EXP_TT)) u_dut_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_sweep(input int m);
    mode = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    sb.push_back(model(m));
    check("start_busy", 32'(bus.busy), 1);
    check("start_stim", 32'(bus.stim), 0);
    check("start_captured_clr", 32'(bus.captured), 0);
    check("start_cnt_clr", 32'(bus.mismatch_cnt), 0);
    check("start_fv_clr", 32'(bus.fail_valid), 0);
    check("start_pass_clr", 32'(bus.pass), 0);
  endtask

  task automatic finish_sweep(input bit repulse, input bit hold_end);
    int j;
    exp_t e;
    j = 0;
    while (bus.done !== 1'b1 && j < 200) begin
      if (j < DEPTH * SETTLE) check("run_stim", 32'(bus.stim), 32'(j / SETTLE));
      if (repulse) begin
        if (j == 9 || j == 19) bus.start = 1'b1;
        else if (j == 10 || j == 20) bus.start = 1'b0;
      end
      if (hold_end && j == DEPTH * SETTLE - 2) bus.start = 1'b1;
      tick();
      j++;
    end
    check("done_latency", 32'(j), 32'(DEPTH * SETTLE));
    check("done_stim", 32'(bus.stim), DEPTH - 1);
    check("done_busy", 32'(bus.busy), 1);
    check("done_pass_pending", 32'(bus.pass), 0);
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("captured", 32'(bus.captured), 32'(e.cap));
      check("mismatch_cnt", 32'(bus.mismatch_cnt), 32'(e.cnt));
      check("fail_valid", 32'(bus.fail_valid), 32'(e.fv));
      check("first_fail", 32'(bus.first_fail), 32'(e.ff));
      tick();
      check("done_pulse", 32'(bus.done), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_stim", 32'(bus.stim), 0);
      check("pass", 32'(bus.pass), 32'(e.pass));
      if (!hold_end) begin
        tick();
        check("pass_held", 32'(bus.pass), 32'(e.pass));
        check("captured_held", 32'(bus.captured), 32'(e.cap));
      end
    end
  endtask

  initial begin
    int j;
    exp_t e;
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_stim", 32'(bus.stim), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_captured", 32'(bus.captured), 0);
    check("rst_cnt", 32'(bus.mismatch_cnt), 0);
    check("rst_fv", 32'(bus.fail_valid), 0);
    check("rst_ff", 32'(bus.first_fail), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_s1_busy", 32'(bus1.busy), 0);
    rst_n = 1'b1;
    tick();

    // majority, stuck-at-0, xor
    begin_sweep(0); finish_sweep(1'b0, 1'b0);
    begin_sweep(1); finish_sweep(1'b0, 1'b0);
    begin_sweep(2); finish_sweep(1'b0, 1'b0);

    // mid-sweep start pulses ignored; start held through DONE restarts from IDLE
    begin_sweep(0); finish_sweep(1'b1, 1'b1);
    begin_sweep(1); finish_sweep(1'b0, 1'b0);

    // reset mid-sweep
    begin_sweep(2);
    repeat (14) tick();
    check("pre_rst_busy", 32'(bus.busy), 1);
    check("pre_rst_fv", 32'(bus.fail_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("midrst_stim", 32'(bus.stim), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_captured", 32'(bus.captured), 0);
    check("midrst_cnt", 32'(bus.mismatch_cnt), 0);
    check("midrst_fv", 32'(bus.fail_valid), 0);
    check("midrst_ff", 32'(bus.first_fail), 0);
    tick();
    check("midrst_stays_idle", 32'(bus.busy), 0);
    begin_sweep(0); finish_sweep(1'b0, 1'b0);

    // SETTLE=1 instance, majority DUT
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    sb.push_back(model(0));
    j = 0;
    while (bus1.done !== 1'b1 && j < 50) begin
      check("s1_stim", 32'(bus1.stim), 32'(j));
      tick();
      j++;
    end
    check("s1_done_latency", 32'(j), DEPTH);
    check("s1_sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("s1_captured", 32'(bus1.captured), 32'(e.cap));
      check("s1_cnt", 32'(bus1.mismatch_cnt), 32'(e.cnt));
      check("s1_fv", 32'(bus1.fail_valid), 32'(e.fv));
      tick();
      check("s1_pass", 32'(bus1.pass), 32'(e.pass));
      check("s1_done_pulse", 32'(bus1.done), 0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
